// File: rtl/acc_writeback_if.sv
// Result/store bundle between the ALU stage, the writeback block and data memory.
// Master drives results and the memory ack; slave is the writeback block.
`timescale 1ns/1ps
interface acc_writeback_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] aluOut;
  logic              carryIn;
  logic              wrAcc;
  logic              wrCarry;
  logic              wrMem;
  logic              negate;
  logic [ADDR_W-1:0] memAddrIn;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic              memWrEn;
  logic [ADDR_W-1:0] memWrAddr;
  logic [DATA_W-1:0] memWrData;
  logic              memAck;
  logic              errTimeout;
  logic              clrErr;
  logic [15:0]       instrCount;

  modport master (
    output inValid, aluOut, carryIn, wrAcc, wrCarry, wrMem, negate, memAddrIn, memAck, clrErr,
    input  inReady, acc, carry, memWrEn, memWrAddr, memWrData, errTimeout, instrCount
  );

  modport slave (
    input  inValid, aluOut, carryIn, wrAcc, wrCarry, wrMem, negate, memAddrIn, memAck, clrErr,
    output inReady, acc, carry, memWrEn, memWrAddr, memWrData, errTimeout, instrCount
  );
endinterface

// File: rtl/acc_writeback.sv
// Accumulator/carry writeback with memory store handshake; acc/carry visible 1 cycle after accept.
// inReady drops for the whole store until memAck or ACK_TIMEOUT cycles expire.
`timescale 1ns/1ps
module acc_writeback #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  acc_writeback_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

  state_t            state, stateNext;
  logic [7:0]        ackCount;
  logic              accept, storeStart, ackTaken, timeoutHit;
  logic [DATA_W-1:0] accQ, memWrDataQ;
  logic [ADDR_W-1:0] memWrAddrQ;
  logic              carryQ, memWrEnQ, errQ;
  logic [15:0]       instrCountQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    bus.inReady = 1'b0;
    accept      = 1'b0;
    storeStart  = 1'b0;
    ackTaken    = 1'b0;
    timeoutHit  = 1'b0;
    case (state)
      IDLE: begin
        bus.inReady = 1'b1;
        accept      = bus.inValid;
        if (bus.inValid && bus.wrMem) begin
          storeStart = 1'b1;
          stateNext  = WRITE;
        end
      end
      WRITE: begin
        // An ack landing on the last allowed cycle takes priority over the timeout.
        if (bus.memAck) begin
          ackTaken  = 1'b1;
          stateNext = IDLE;
        end else if (ackCount == LAST_CNT) begin
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accQ        <= '0;
      carryQ      <= 1'b0;
      memWrEnQ    <= 1'b0;
      memWrAddrQ  <= '0;
      memWrDataQ  <= '0;
      errQ        <= 1'b0;
      instrCountQ <= 16'd0;
      ackCount    <= 8'd0;
    end else begin
      if (accept) begin
        instrCountQ <= instrCountQ + 16'd1;
        if (bus.wrAcc)   accQ   <= bus.negate ? ~bus.aluOut : bus.aluOut;
        if (bus.wrCarry) carryQ <= bus.carryIn;
      end
      // Store captures the accumulator as it was before this accept's update.
      if (storeStart) begin
        memWrDataQ <= bus.negate ? ~accQ : accQ;
        memWrAddrQ <= bus.memAddrIn;
        memWrEnQ   <= 1'b1;
        ackCount   <= 8'd0;
      end else if (ackTaken || timeoutHit) begin
        memWrEnQ <= 1'b0;
      end else if (state == WRITE) begin
        ackCount <= ackCount + 8'd1;
      end
      if (timeoutHit)      errQ <= 1'b1;
      else if (bus.clrErr) errQ <= 1'b0;
    end
  end

  assign bus.acc        = accQ;
  assign bus.carry      = carryQ;
  assign bus.memWrEn    = memWrEnQ;
  assign bus.memWrAddr  = memWrAddrQ;
  assign bus.memWrData  = memWrDataQ;
  assign bus.errTimeout = errQ;
  assign bus.instrCount = instrCountQ;
endmodule

// File: tb/tb_acc_writeback.sv
// Testbench for acc_writeback: vector table, directed store/timeout/reset sequences,
// counter wrap, then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_acc_writeback;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nVec = 0;
  int   nMis = 0;

  acc_writeback_if #(.DATA_W(8), .ADDR_W(8)) busIf ();

  acc_writeback #(.DATA_W(8), .ADDR_W(8), .ACK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inValid;
    logic       wrAcc;
    logic       wrCarry;
    logic       negate;
    logic [7:0] aluOut;
    logic       carryIn;
    logic [7:0] eAcc;
    logic       eCarry;
    logic [15:0] eCnt;
  } vec_t;

  vec_t tbl[6];

  // Reference model: a store is a pending transaction that ends on ack or after TO waited cycles.
  logic [7:0]  mAcc, mData, mAddr;
  logic        mCarry, mErr, mBusy;
  logic [15:0] mCnt;
  int          mWaited;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    busIf.inValid = 0; busIf.wrAcc = 0; busIf.wrCarry = 0; busIf.wrMem = 0;
    busIf.negate = 0; busIf.aluOut = '0; busIf.carryIn = 0; busIf.memAddrIn = '0;
    busIf.memAck = 0; busIf.clrErr = 0;
  endtask

  task automatic store(input logic [7:0] addr, input logic neg);
    busIf.inValid = 1; busIf.wrMem = 1; busIf.memAddrIn = addr; busIf.negate = neg;
    tick();
    idleIn();
  endtask

  task automatic doReset();
    reset = 1;
    #2;
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic modelStep();
    logic setErr;
    setErr = 0;
    if (mBusy) begin
      mWaited++;
      if (busIf.memAck) mBusy = 0;
      else if (mWaited >= TO) begin mBusy = 0; setErr = 1; end
    end else if (busIf.inValid) begin
      mCnt++;
      if (busIf.wrMem) begin
        mData = busIf.negate ? ~mAcc : mAcc;
        mAddr = busIf.memAddrIn;
        mBusy = 1;
        mWaited = 0;
      end
      if (busIf.wrAcc)   mAcc   = busIf.negate ? ~busIf.aluOut : busIf.aluOut;
      if (busIf.wrCarry) mCarry = busIf.carryIn;
    end
    if (setErr) mErr = 1;
    else if (busIf.clrErr) mErr = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idleIn();
    // Reset state, checked while reset is still asserted
    reset = 1;
    #7;
    chk("rst_acc",   32'(busIf.acc), 0);
    chk("rst_wren",  32'(busIf.memWrEn), 0);
    chk("rst_cnt",   32'(busIf.instrCount), 0);
    chk("rst_err",   32'(busIf.errTimeout), 0);
    chk("rst_waddr", 32'(busIf.memWrAddr), 0);
    chk("rst_wdata", 32'(busIf.memWrData), 0);
    chk("rst_carry", 32'(busIf.carry), 0);
    @(posedge clk);
    #1 reset = 0;
    tick();
    chk("rst_ready", 32'(busIf.inReady), 1);

    // Back-to-back non-store accepts
    tbl[0] = '{1, 1, 0, 1, 8'h3C, 0, 8'hC3, 0, 16'd1};
    tbl[1] = '{1, 1, 1, 0, 8'h5A, 1, 8'h5A, 1, 16'd2};
    tbl[2] = '{1, 0, 1, 1, 8'hFF, 0, 8'h5A, 0, 16'd3};
    tbl[3] = '{1, 1, 1, 1, 8'h00, 1, 8'hFF, 1, 16'd4};
    tbl[4] = '{1, 1, 0, 0, 8'h5A, 0, 8'h5A, 1, 16'd5};
    tbl[5] = '{0, 1, 1, 0, 8'h77, 0, 8'h5A, 1, 16'd5};
    for (int i = 0; i < 6; i++) begin
      busIf.inValid = tbl[i].inValid; busIf.wrAcc = tbl[i].wrAcc;
      busIf.wrCarry = tbl[i].wrCarry; busIf.negate = tbl[i].negate;
      busIf.aluOut = tbl[i].aluOut;   busIf.carryIn = tbl[i].carryIn;
      tick();
      chk($sformatf("tbl%0d_acc", i),   32'(busIf.acc), 32'(tbl[i].eAcc));
      chk($sformatf("tbl%0d_carry", i), 32'(busIf.carry), 32'(tbl[i].eCarry));
      chk($sformatf("tbl%0d_cnt", i),   32'(busIf.instrCount), 32'(tbl[i].eCnt));
      chk($sformatf("tbl%0d_ready", i), 32'(busIf.inReady), 1);
    end
    idleIn();

    // Store of old acc with simultaneous acc update; held inValid is ignored while busy
    busIf.inValid = 1; busIf.wrMem = 1; busIf.wrAcc = 1; busIf.aluOut = 8'h11; busIf.memAddrIn = 8'h20;
    tick();
    chk("st_wren",  32'(busIf.memWrEn), 1);
    chk("st_wdata", 32'(busIf.memWrData), 'h5A);
    chk("st_waddr", 32'(busIf.memWrAddr), 'h20);
    chk("st_acc",   32'(busIf.acc), 'h11);
    busIf.wrMem = 0; busIf.aluOut = 8'h99; busIf.memAddrIn = 8'h55;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_hold_ready", 32'(busIf.inReady), 0);
      chk("st_hold_acc",   32'(busIf.acc), 'h11);
      chk("st_hold_addr",  32'(busIf.memWrAddr), 'h20);
      chk("st_hold_wren",  32'(busIf.memWrEn), 1);
    end
    busIf.memAck = 1;
    tick();
    idleIn();
    chk("st_ack_wren",  32'(busIf.memWrEn), 0);
    chk("st_ack_ready", 32'(busIf.inReady), 1);
    chk("st_ack_cnt",   32'(busIf.instrCount), 6);

    // Timeout after TO cycles, then clear
    store(8'h30, 1);
    chk("to_wdata", 32'(busIf.memWrData), 'hEE);
    chk("to_wren0", 32'(busIf.memWrEn), 1);
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_wren", 32'(busIf.memWrEn), 1);
      chk("to_err0", 32'(busIf.errTimeout), 0);
    end
    tick();
    chk("to_wren_off", 32'(busIf.memWrEn), 0);
    chk("to_err",      32'(busIf.errTimeout), 1);
    chk("to_ready",    32'(busIf.inReady), 1);
    busIf.clrErr = 1;
    tick();
    busIf.clrErr = 0;
    chk("to_clr", 32'(busIf.errTimeout), 0);

    // clrErr on the timeout edge: set wins
    store(8'h31, 0);
    repeat (TO - 1) tick();
    busIf.clrErr = 1;
    tick();
    busIf.clrErr = 0;
    chk("to_setwins", 32'(busIf.errTimeout), 1);
    busIf.clrErr = 1;
    tick();
    busIf.clrErr = 0;
    chk("to_clr2", 32'(busIf.errTimeout), 0);

    // Ack on the last allowed cycle beats the timeout
    store(8'h32, 0);
    repeat (TO - 1) tick();
    busIf.memAck = 1;
    tick();
    busIf.memAck = 0;
    chk("late_ack_wren", 32'(busIf.memWrEn), 0);
    chk("late_ack_err",  32'(busIf.errTimeout), 0);

    // memAck while idle must not cut the new store short
    busIf.memAck = 1;
    busIf.inValid = 1; busIf.wrMem = 1; busIf.memAddrIn = 8'h44;
    tick();
    busIf.inValid = 0; busIf.wrMem = 0;
    chk("idle_ack_wren",  32'(busIf.memWrEn), 1);
    chk("idle_ack_ready", 32'(busIf.inReady), 0);
    tick();
    busIf.memAck = 0;
    chk("idle_ack_done", 32'(busIf.memWrEn), 0);
    chk("idle_ack_cnt",  32'(busIf.instrCount), 10);

    // Reset mid-store clears everything including a set error flag
    store(8'h50, 0);
    repeat (TO - 1) tick();
    tick();
    chk("pre_rst_err", 32'(busIf.errTimeout), 1);
    store(8'h51, 0);
    tick();
    chk("pre_rst_wren", 32'(busIf.memWrEn), 1);
    reset = 1;
    #1;
    chk("mid_rst_wren",  32'(busIf.memWrEn), 0);
    chk("mid_rst_err",   32'(busIf.errTimeout), 0);
    chk("mid_rst_acc",   32'(busIf.acc), 0);
    chk("mid_rst_cnt",   32'(busIf.instrCount), 0);
    chk("mid_rst_ready", 32'(busIf.inReady), 1);
    chk("mid_rst_waddr", 32'(busIf.memWrAddr), 0);
    @(posedge clk);
    #1 reset = 0;

    // instrCount wrap, then acc tracks aluOut with one cycle lag
    busIf.inValid = 1;
    repeat (65535) tick();
    chk("cnt_ffff", 32'(busIf.instrCount), 'hFFFF);
    tick();
    chk("cnt_wrap", 32'(busIf.instrCount), 0);
    busIf.wrAcc = 1;
    for (int i = 1; i <= 3; i++) begin
      busIf.aluOut = 8'(8'hA0 + i);
      tick();
      chk("track_acc", 32'(busIf.acc), 32'(8'hA0 + i));
      chk("track_cnt", 32'(busIf.instrCount), 32'(i));
    end
    idleIn();

    // Randomized traffic against the reference model
    doReset();
    mAcc = 0; mData = 0; mAddr = 0; mCarry = 0; mErr = 0; mBusy = 0; mCnt = 0; mWaited = 0;
    for (int c = 0; c < 600; c++) begin
      busIf.inValid   = ($urandom_range(0, 9) < 7);
      busIf.wrAcc     = 1'($urandom);
      busIf.wrCarry   = 1'($urandom);
      busIf.wrMem     = ($urandom_range(0, 9) < 3);
      busIf.negate    = 1'($urandom);
      busIf.aluOut    = 8'($urandom);
      busIf.carryIn   = 1'($urandom);
      busIf.memAddrIn = 8'($urandom);
      busIf.memAck    = ($urandom_range(0, 5) == 0);
      busIf.clrErr    = ($urandom_range(0, 9) == 0);
      chk("rnd_ready", 32'(busIf.inReady), 32'(!mBusy));
      @(posedge clk);
      modelStep();
      #1;
      chk("rnd_acc",   32'(busIf.acc), 32'(mAcc));
      chk("rnd_carry", 32'(busIf.carry), 32'(mCarry));
      chk("rnd_wren",  32'(busIf.memWrEn), 32'(mBusy));
      chk("rnd_waddr", 32'(busIf.memWrAddr), 32'(mAddr));
      chk("rnd_wdata", 32'(busIf.memWrData), 32'(mData));
      chk("rnd_err",   32'(busIf.errTimeout), 32'(mErr));
      chk("rnd_cnt",   32'(busIf.instrCount), 32'(mCnt));
    end
    idleIn();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
